board_renderer: RTL and testbench



---
 rtl/board_pkg.sv | 20 ++
 rtl/board_renderer_cell_colour_sel.sv | 42 ++++
 rtl/board_renderer.sv | 187 ++++++++++++++++++
 tb/tb_board_renderer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants for the board renderer: grid size, 3-bit RGB palette and FSM states.
package board_pkg;

    localparam int unsigned GRID_N     = 8;
    localparam logic [2:0]  CELL_LAST  = 3'(GRID_N - 1);

    localparam logic [2:0] COL_EMPTY    = 3'b000;
    localparam logic [2:0] COL_LINE     = 3'b001;
    localparam logic [2:0] COL_FILLED   = 3'b010;
    localparam logic [2:0] COL_GHOST    = 3'b110;
    localparam logic [2:0] COL_CONFLICT = 3'b100;
    localparam logic [2:0] COL_OVER     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/board_renderer_cell_colour_sel.sv
// Combinational palette lookup for one board cell: grid line, overlay conflict/ghost,
// filled (normal or game-over) or empty.
module cell_colour_sel
    import board_pkg::*;
(
    input  logic [63:0] grid_i,
    input  logic [63:0] block_i,
    input  logic [2:0]  ox_i,
    input  logic [2:0]  oy_i,
    input  logic        game_over_i,
    input  logic [2:0]  r_i,
    input  logic [2:0]  c_i,
    input  logic        border_i,
    output logic [2:0]  colour_o
);

    logic [3:0] dr;
    logic [3:0] dc;
    logic       hit;
    logic       filled;

    always_comb begin
        // 4-bit signed offsets: bit 3 set means the cell lies above/left of the block origin
        dr     = {1'b0, r_i} - {1'b0, oy_i};
        dc     = {1'b0, c_i} - {1'b0, ox_i};
        hit    = ~dr[3] & ~dc[3] & block_i[{dr[2:0], dc[2:0]}];
        filled = grid_i[{r_i, c_i}];

        if (border_i) begin
            colour_o = COL_LINE;
        end else if (hit && filled) begin
            colour_o = COL_CONFLICT;
        end else if (hit) begin
            colour_o = COL_GHOST;
        end else if (filled) begin
            colour_o = game_over_i ? COL_OVER : COL_FILLED;
        end else begin
            colour_o = COL_EMPTY;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Paints one 8x8 board frame into the VGA adapter, one pixel per clock, from a
// snapshot of the game state taken on the accepted start.
module board_renderer
    import board_pkg::*;
#(
    parameter int unsigned CELL_PX  = 12,
    parameter int unsigned ORIGIN_X = 32,
    parameter int unsigned ORIGIN_Y = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] game_grid,
    input  logic [63:0] block1,
    input  logic [63:0] block2,
    input  logic [63:0] block3,
    input  logic [2:0]  block1_x,
    input  logic [2:0]  block1_y,
    input  logic [2:0]  block2_x,
    input  logic [2:0]  block2_y,
    input  logic [2:0]  block3_x,
    input  logic [2:0]  block3_y,
    input  logic [1:0]  sel,
    input  logic        game_over,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int unsigned     PW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [PW-1:0]   PX_LAST = PW'(CELL_PX - 1);

    state_e        state_q;
    logic [2:0]    r_q, c_q, r_d, c_d;
    logic [PW-1:0] py_q, px_q, py_d, px_d;
    logic [63:0]   grid_q, blk_q;
    logic [2:0]    ox_q, oy_q;
    logic          over_q;
    logic [7:0]    vga_x_q, x_d;
    logic [6:0]    vga_y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, busy_q, done_q;

    logic [63:0]   blk_sel;
    logic [2:0]    ox_sel, oy_sel;
    logic          last_pix;
    logic          border_d;

    always_comb begin
        blk_sel = '0;
        ox_sel  = '0;
        oy_sel  = '0;
        case (sel)
            2'd1: begin blk_sel = block1; ox_sel = block1_x; oy_sel = block1_y; end
            2'd2: begin blk_sel = block2; ox_sel = block2_x; oy_sel = block2_y; end
            2'd3: begin blk_sel = block3; ox_sel = block3_x; oy_sel = block3_y; end
            default: ;
        endcase
    end

    // Counters always name the pixel currently on the outputs; the wrap after the
    // final pixel returns them all to zero, so they are already cleared in IDLE.
    always_comb begin
        r_d  = r_q;
        c_d  = c_q;
        py_d = py_q;
        px_d = px_q;
        last_pix = (r_q == CELL_LAST) && (c_q == CELL_LAST) &&
                   (py_q == PX_LAST) && (px_q == PX_LAST);
        if (state_q == ST_DRAW) begin
            if (px_q != PX_LAST) begin
                px_d = px_q + 1'b1;
            end else begin
                px_d = '0;
                if (py_q != PX_LAST) begin
                    py_d = py_q + 1'b1;
                end else begin
                    py_d = '0;
                    if (c_q != CELL_LAST) begin
                        c_d = c_q + 3'd1;
                    end else begin
                        c_d = '0;
                        r_d = r_q + 3'd1;
                    end
                end
            end
        end
        border_d = (px_d == '0) || (py_d == '0);
        x_d = 8'(ORIGIN_X) + 8'(c_d) * 8'(CELL_PX) + 8'(px_d);
        y_d = 7'(ORIGIN_Y) + 7'(r_d) * 7'(CELL_PX) + 7'(py_d);
    end

    // The first pixel of a frame is always a border pixel, so the not-yet-loaded
    // snapshot never influences the colour registered on the start edge.
    cell_colour_sel u_colour (
        .grid_i      (grid_q),
        .block_i     (blk_q),
        .ox_i        (ox_q),
        .oy_i        (oy_q),
        .game_over_i (over_q),
        .r_i         (r_d),
        .c_i         (c_d),
        .border_i    (border_d),
        .colour_o    (colour_d)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            py_q     <= '0;
            px_q     <= '0;
            grid_q   <= '0;
            blk_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            over_q   <= 1'b0;
            vga_x_q  <= '0;
            vga_y_q  <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            r_q  <= r_d;
            c_q  <= c_d;
            py_q <= py_d;
            px_q <= px_d;
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        grid_q   <= game_grid;
                        blk_q    <= blk_sel;
                        ox_q     <= ox_sel;
                        oy_q     <= oy_sel;
                        over_q   <= game_over;
                        vga_x_q  <= x_d;
                        vga_y_q  <= y_d;
                        colour_q <= colour_d;
                        plot_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (last_pix) begin
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        vga_x_q  <= x_d;
                        vga_y_q  <= y_d;
                        colour_q <= colour_d;
                        plot_q   <= 1'b1;
                    end
                end
                ST_FIN: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vga_x  = vga_x_q;
    assign vga_y  = vga_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench: per-frame pixel scoreboard from an independent screen-space model,
// plus spot checks on the captured image.
module tb_board_renderer;

    localparam int CELL = 12;
    localparam int OX   = 32;
    localparam int OY   = 12;
    localparam int N    = 64 * CELL * CELL;

    logic        clk = 1'b0;
    logic        resetn, start, game_over;
    logic [63:0] game_grid, block1, block2, block3;
    logic [2:0]  block1_x, block1_y, block2_x, block2_y, block3_x, block3_y;
    logic [1:0]  sel;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int compared   = 0;
    int mismatched = 0;

    logic [17:0] q[$];
    logic [2:0]  img [160][120];
    int          plot_cnt, done_cnt, done_at;

    board_renderer #(.CELL_PX(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .game_grid(game_grid), .block1(block1), .block2(block2), .block3(block3),
        .block1_x(block1_x), .block1_y(block1_y),
        .block2_x(block2_x), .block2_y(block2_y),
        .block3_x(block3_x), .block3_y(block3_y),
        .sel(sel), .game_over(game_over),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Screen-space model: locate the cell from the absolute pixel position.
    function automatic logic [2:0] model_col(input int X, input int Y, input logic [63:0] g,
                                             input logic [63:0] b, input int bx, input int by,
                                             input bit go);
        int xo, yo, r, c, px, py, dr, dc;
        bit hit, f;
        xo = X - OX; yo = Y - OY;
        c = xo / CELL; px = xo % CELL;
        r = yo / CELL; py = yo % CELL;
        dr = r - by; dc = c - bx;
        hit = (dr >= 0) && (dr <= 7) && (dc >= 0) && (dc <= 7) && b[dr * 8 + dc];
        f = g[r * 8 + c];
        if (px == 0 || py == 0) return 3'b001;
        if (hit && f)           return 3'b100;
        if (hit)                return 3'b110;
        if (f)                  return go ? 3'b101 : 3'b010;
        return 3'b000;
    endfunction

    task automatic run_frame(input bit disturb, input int abort_at);
        logic [63:0] b;
        int bx, by;
        logic [17:0] e;
        b = '0; bx = 0; by = 0;
        case (sel)
            2'd1: begin b = block1; bx = int'(block1_x); by = int'(block1_y); end
            2'd2: begin b = block2; bx = int'(block2_x); by = int'(block2_y); end
            2'd3: begin b = block3; bx = int'(block3_x); by = int'(block3_y); end
            default: ;
        endcase
        q.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int py = 0; py < CELL; py++)
                    for (int px = 0; px < CELL; px++) begin
                        int X, Y;
                        X = OX + c * CELL + px;
                        Y = OY + r * CELL + py;
                        q.push_back({8'(X), 7'(Y), model_col(X, Y, game_grid, b, bx, by, game_over)});
                    end
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                img[x][y] = 3'b111;
        plot_cnt = 0; done_cnt = 0; done_at = 0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = disturb;
        for (int i = 1; i <= N + 2; i++) begin
            @(negedge clk);
            if (plot === 1'b1) plot_cnt++;
            if (done === 1'b1) begin done_cnt++; done_at = i; end
            if (i <= N) begin
                e = (q.size() > 0) ? q.pop_front() : 18'h3ffff;
                if (plot === 1'b1 && int'(vga_x) < 160 && int'(vga_y) < 120)
                    img[vga_x][vga_y] = colour;
                check("pixel", 32'({plot, busy, done, vga_x, vga_y, colour}), 32'({3'b110, e}));
            end else if (i == N + 1) begin
                check("fin", 32'({plot, busy, done}), 32'(3'b011));
            end else begin
                check("idle_after", 32'({plot, busy, done}), 32'(3'b000));
            end
            if (i == abort_at) begin
                resetn = 1'b0;
                @(negedge clk);
                check("abort", 32'({plot, busy, done}), 32'(3'b000));
                @(negedge clk);
                check("abort_hold", 32'({plot, busy, done}), 32'(3'b000));
                resetn = 1'b1;
                q.delete();
                return;
            end
            if (disturb && i <= N) begin
                game_grid = {$urandom, $urandom};
                game_over = ~game_over;
                block1_x  = 3'($urandom);
                start     = 1'b1;
            end else if (disturb && i == N + 1) begin
                start = 1'b0;
            end
        end
        check("frame_len", 32'(plot_cnt), 32'(N));
        check("done_cnt", 32'(done_cnt), 32'(1));
        check("done_at", 32'(done_at), 32'(N + 1));
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; game_over = 1'b0; sel = 2'd0;
        game_grid = '0; block1 = '0; block2 = '0; block3 = '0;
        block1_x = '0; block1_y = '0; block2_x = '0; block2_y = '0;
        block3_x = '0; block3_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 32'({vga_x, vga_y, colour, plot, busy, done}), 32'(0));
        resetn = 1'b1;

        // Empty board
        run_frame(1'b0, 0);
        check("empty_32_12", 32'(img[32][12]), 32'(3'b001));
        check("empty_33_13", 32'(img[33][13]), 32'(3'b000));

        // One filled cell, normal then game-over palette
        game_grid = 64'h1;
        run_frame(1'b0, 0);
        for (int x = 33; x <= 43; x += 5)
            for (int y = 13; y <= 23; y += 5)
                check("filled_cell", 32'(img[x][y]), 32'(3'b010));
        check("filled_44_12", 32'(img[44][12]), 32'(3'b001));
        game_over = 1'b1;
        run_frame(1'b0, 0);
        check("over_33_13", 32'(img[33][13]), 32'(3'b101));
        check("over_43_23", 32'(img[43][23]), 32'(3'b101));
        game_over = 1'b0;

        // Overlay ghost and conflict
        sel = 2'd1; block1 = 64'h3; block1_x = 3'd6; block1_y = 3'd7;
        game_grid = 64'h8000_0000_0000_0000;
        run_frame(1'b0, 0);
        check("ghost_7_6", 32'(img[OX + 6 * CELL + 5][OY + 7 * CELL + 5]), 32'(3'b110));
        check("conflict_7_7", 32'(img[OX + 7 * CELL + 5][OY + 7 * CELL + 5]), 32'(3'b100));
        check("empty_7_5", 32'(img[OX + 5 * CELL + 5][OY + 7 * CELL + 5]), 32'(3'b000));
        check("empty_6_6", 32'(img[OX + 6 * CELL + 5][OY + 6 * CELL + 5]), 32'(3'b000));

        // Inputs churn and start held high during the frame
        run_frame(1'b1, 0);
        check("snap_ghost", 32'(img[OX + 6 * CELL + 5][OY + 7 * CELL + 5]), 32'(3'b110));

        // Next start accepted, then reset at draw cycle 100
        run_frame(1'b0, 100);

        // Fresh full frame after reset
        sel = 2'd0; game_grid = '0; game_over = 1'b0;
        run_frame(1'b0, 0);
        check("post_reset_32_12", 32'(img[32][12]), 32'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
